// File: rtl/telem_pkg.sv
// Shared definitions for telemetry_framer: FSM encoding, frame layout,
// snapshot record and the frame byte selector.
package telem_pkg;

  // Framer FSM encoding.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_REQ   = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  localparam int FRAME_LEN = 9;

  // Byte positions inside one frame.
  localparam logic [3:0] IDX_SYNC  = 4'd0;
  localparam logic [3:0] IDX_SEQ   = 4'd1;
  localparam logic [3:0] IDX_SP_H  = 4'd2;
  localparam logic [3:0] IDX_SP_L  = 4'd3;
  localparam logic [3:0] IDX_S_H   = 4'd4;
  localparam logic [3:0] IDX_S_L   = 4'd5;
  localparam logic [3:0] IDX_PID_H = 4'd6;
  localparam logic [3:0] IDX_PID_L = 4'd7;
  localparam logic [3:0] IDX_CHK   = 4'(FRAME_LEN - 1);

  // CRC-8 polynomial and the number of bytes it covers (SEQ..PID_L).
  localparam logic [7:0] CRC8_POLY  = 8'h07;
  localparam int         CRC_CYCLES = 7;

  // Values frozen for the lifetime of one frame.
  typedef struct packed {
    logic [7:0]  seq;
    logic [15:0] sp;
    logic [15:0] sens;
    logic [15:0] pid;
  } snap_t;

  // Byte 'idx' of a frame built from a snapshot and its check byte.
  function automatic logic [7:0] frame_byte(input logic [3:0] idx,
                                            input logic [7:0] sync,
                                            input snap_t      snap,
                                            input logic [7:0] chk);
    logic [7:0] b;
    case (idx)
      IDX_SYNC:  b = sync;
      IDX_SEQ:   b = snap.seq;
      IDX_SP_H:  b = snap.sp[15:8];
      IDX_SP_L:  b = snap.sp[7:0];
      IDX_S_H:   b = snap.sens[15:8];
      IDX_S_L:   b = snap.sens[7:0];
      IDX_PID_H: b = snap.pid[15:8];
      IDX_PID_L: b = snap.pid[7:0];
      default:   b = chk;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/crc8_step.sv
// crc8_step: one byte of CRC-8 (poly 0x07, MSB first, no reflection).
// Only present when TELEM_CRC8_EN is defined; the XOR build never uses it.
`ifdef TELEM_CRC8_EN
module crc8_step
  import telem_pkg::*;
(
  input  logic [7:0] crc_in,
  input  logic [7:0] byte_in,
  output logic [7:0] crc_out
);

  logic [7:0] crc_v;

  // Fold the byte into the register, then shift out eight bits.
  always_comb begin
    crc_v = crc_in ^ byte_in;
    for (int b = 0; b < 8; b++) begin
      if (crc_v[7]) crc_v = {crc_v[6:0], 1'b0} ^ CRC8_POLY;
      else          crc_v = {crc_v[6:0], 1'b0};
    end
    crc_out = crc_v;
  end

endmodule
`endif

// File: rtl/telemetry_framer.sv
// telemetry_framer: every PERIOD_TICKS clk_en_i ticks, snapshot setpoint,
// sensor value and PID output and stream them as a 9-byte frame
// (SYNC, SEQ, SP_H, SP_L, S_H, S_L, PID_H, PID_L, CHK) to a UART.
// Build option TELEM_CRC8_EN: CHK is CRC-8/0x07 over bytes 1..7, computed
// one byte per cycle in a 7-cycle LOAD; otherwise CHK is their XOR and
// LOAD lasts one cycle.
// UART handshake: ser_send_o rises with ser_data_o valid and both hold
// until ser_busy_i is seen high; send then drops the next cycle and the
// next byte is offered only after ser_busy_i has returned low.
module telemetry_framer
  import telem_pkg::*;
#(
  parameter int         PERIOD_TICKS = 100,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
  input  logic        clk_in_i,
  input  logic        reset_i,
  input  logic        clk_en_i,
  input  logic        enable_i,
  input  logic [15:0] sp_i,
  input  logic [15:0] sens_data_i,
  input  logic [15:0] pid_out_i,
  input  logic        ser_busy_i,
  output logic        ser_send_o,
  output logic [7:0]  ser_data_o,
  output logic [7:0]  frame_cnt_o,
  output logic        overrun_o,
  input  logic        overrun_clr_i
);

  localparam int                TICK_W   = $clog2(PERIOD_TICKS);
  localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(PERIOD_TICKS - 1);

  logic [TICK_W-1:0] tick_q, tick_d;
  logic              frame_req;

  state_e            state_q, state_d;
  logic [3:0]        idx_q, idx_d;
  snap_t             snap_q, snap_d;
  logic [7:0]        chk_q, chk_d;
  logic              ser_send_q, ser_send_d;
  logic [7:0]        ser_data_q, ser_data_d;
  logic [7:0]        frame_cnt_q, frame_cnt_d;
  logic              overrun_q, overrun_d;

`ifdef TELEM_CRC8_EN
  logic [2:0]        crc_cnt_q, crc_cnt_d;
  logic [7:0]        crc_byte;
  logic [7:0]        crc_next;

  // chk_q doubles as the running CRC while in LOAD; crc_cnt_q walks SEQ..PID_L.
  assign crc_byte = frame_byte({1'b0, crc_cnt_q} + IDX_SEQ, SYNC_BYTE, snap_q, chk_q);

  crc8_step u_crc8_step (
    .crc_in  (chk_q),
    .byte_in (crc_byte),
    .crc_out (crc_next)
  );
`else
  logic [7:0]        xor_chk;

  // XOR of SEQ..PID_L taken from the frozen snapshot.
  assign xor_chk = snap_q.seq ^ snap_q.sp[15:8] ^ snap_q.sp[7:0] ^
                   snap_q.sens[15:8] ^ snap_q.sens[7:0] ^
                   snap_q.pid[15:8] ^ snap_q.pid[7:0];
`endif

  // Free-running period counter; frame_req is the one-cycle wrap strobe.
  always_comb begin
    tick_d    = tick_q;
    frame_req = 1'b0;
    if (clk_en_i) begin
      if (tick_q == TICK_MAX) begin
        tick_d    = '0;
        frame_req = 1'b1;
      end else begin
        tick_d = tick_q + 1'b1;
      end
    end
  end

  // Sticky overrun: a period boundary outside IDLE sets it; set beats clear.
  always_comb begin
    overrun_d = overrun_q;
    if (overrun_clr_i) overrun_d = 1'b0;
    if (frame_req && (state_q != ST_IDLE)) overrun_d = 1'b1;
  end

  // Frame sequencing: snapshot on entry to LOAD, then one REQ/DRAIN pair per byte.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    snap_d      = snap_q;
    chk_d       = chk_q;
    ser_send_d  = ser_send_q;
    ser_data_d  = ser_data_q;
    frame_cnt_d = frame_cnt_q;
`ifdef TELEM_CRC8_EN
    crc_cnt_d   = crc_cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        // A request with enable low is simply ignored.
        if (frame_req && enable_i) begin
          state_d = ST_LOAD;
          snap_d  = '{seq: frame_cnt_q, sp: sp_i, sens: sens_data_i, pid: pid_out_i};
          chk_d   = 8'h00;
`ifdef TELEM_CRC8_EN
          crc_cnt_d = 3'd0;
`endif
        end
      end
      ST_LOAD: begin
`ifdef TELEM_CRC8_EN
        chk_d     = crc_next;
        crc_cnt_d = crc_cnt_q + 3'd1;
        if (crc_cnt_q == 3'(CRC_CYCLES - 1)) begin
          state_d    = ST_REQ;
          idx_d      = IDX_SYNC;
          ser_send_d = 1'b1;
          ser_data_d = SYNC_BYTE;
        end
`else
        chk_d      = xor_chk;
        state_d    = ST_REQ;
        idx_d      = IDX_SYNC;
        ser_send_d = 1'b1;
        ser_data_d = SYNC_BYTE;
`endif
      end
      ST_REQ: begin
        // Hold the byte until the UART acknowledges by going busy.
        if (ser_busy_i) begin
          state_d    = ST_DRAIN;
          ser_send_d = 1'b0;
        end
      end
      ST_DRAIN: begin
        if (!ser_busy_i) begin
          if (idx_q == IDX_CHK) begin
            state_d     = ST_IDLE;
            frame_cnt_d = frame_cnt_q + 8'd1;
          end else begin
            state_d    = ST_REQ;
            idx_d      = idx_q + 4'd1;
            ser_send_d = 1'b1;
            ser_data_d = frame_byte(idx_q + 4'd1, SYNC_BYTE, snap_q, chk_q);
          end
        end
      end
      default: begin
        state_d    = ST_IDLE;
        ser_send_d = 1'b0;
      end
    endcase
  end

  // State register; reset drops any frame in flight and clears all outputs.
  always_ff @(posedge clk_in_i or negedge reset_i) begin
    if (!reset_i) begin
      tick_q      <= '0;
      state_q     <= ST_IDLE;
      idx_q       <= IDX_SYNC;
      snap_q      <= '0;
      chk_q       <= 8'h00;
      ser_send_q  <= 1'b0;
      ser_data_q  <= 8'h00;
      frame_cnt_q <= 8'h00;
      overrun_q   <= 1'b0;
`ifdef TELEM_CRC8_EN
      crc_cnt_q   <= 3'd0;
`endif
    end else begin
      tick_q      <= tick_d;
      state_q     <= state_d;
      idx_q       <= idx_d;
      snap_q      <= snap_d;
      chk_q       <= chk_d;
      ser_send_q  <= ser_send_d;
      ser_data_q  <= ser_data_d;
      frame_cnt_q <= frame_cnt_d;
      overrun_q   <= overrun_d;
`ifdef TELEM_CRC8_EN
      crc_cnt_q   <= crc_cnt_d;
`endif
    end
  end

  assign ser_send_o  = ser_send_q;
  assign ser_data_o  = ser_data_q;
  assign frame_cnt_o = frame_cnt_q;
  assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_telemetry_framer.sv
// Bench for telemetry_framer: directed frames plus a random-data run through
// the 255->0 frame counter wrap. A UART model answers ser_send_o with a
// programmable busy time and checks every captured byte against exp_q.
module tb_telemetry_framer;

  localparam int PT = 4;

  // clock / reset block
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clk_en = 1'b0;
  logic        enable = 1'b0;
  logic        busy = 1'b0;
  logic        clr = 1'b0;
  logic [15:0] sp = '0;
  logic [15:0] sens = '0;
  logic [15:0] pid = '0;
  logic        send;
  logic [7:0]  data;
  logic [7:0]  fcnt;
  logic        ovr;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  int         busy_len = 1;
  bit         uart_stall = 1'b0;
  int         hold_cnt = 0;

  always #5 clk = ~clk;

  telemetry_framer #(.PERIOD_TICKS(PT), .SYNC_BYTE(8'hA5)) dut (
    .clk_in_i      (clk),
    .reset_i       (rst_n),
    .clk_en_i      (clk_en),
    .enable_i      (enable),
    .sp_i          (sp),
    .sens_data_i   (sens),
    .pid_out_i     (pid),
    .ser_busy_i    (busy),
    .ser_send_o    (send),
    .ser_data_o    (data),
    .frame_cnt_o   (fcnt),
    .overrun_o     (ovr),
    .overrun_clr_i (clr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // UART model / scoreboard consumer
  initial begin
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        busy = 1'b0;
      end else if (busy) begin
        check("send_low_while_busy", {31'd0, send}, 32'd0);
        if (hold_cnt > 0) hold_cnt--;
        else busy = 1'b0;
      end else if (send && !uart_stall) begin
        check("byte_expected", {31'd0, exp_q.size() > 0}, 32'd1);
        if (exp_q.size() > 0) begin
          logic [7:0] e;
          e = exp_q.pop_front();
          check("byte", {24'd0, data}, {24'd0, e});
        end
        busy = 1'b1;
        hold_cnt = busy_len;
      end
    end
  end

  // driver tasks
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic tick(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      clk_en = 1'b1;
      step(1);
      clk_en = 1'b0;
      step(gap);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clk_en = 1'b0;
    clr = 1'b0;
    exp_q.delete();
    step(1);
    check("rst_send", {31'd0, send}, 32'd0);
    check("rst_data", {24'd0, data}, 32'd0);
    check("rst_fcnt", {24'd0, fcnt}, 32'd0);
    check("rst_ovr", {31'd0, ovr}, 32'd0);
    step(1);
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic push_frame(input logic [7:0] seq, input logic [15:0] s_p,
                            input logic [15:0] s_s, input logic [15:0] s_pid);
    logic [7:0] b[9];
    logic [7:0] c;
    b[0] = 8'hA5; b[1] = seq;
    b[2] = s_p[15:8];   b[3] = s_p[7:0];
    b[4] = s_s[15:8];   b[5] = s_s[7:0];
    b[6] = s_pid[15:8]; b[7] = s_pid[7:0];
    c = 8'h00;
    for (int k = 1; k < 8; k++) begin
`ifdef TELEM_CRC8_EN
      c = c ^ b[k];
      for (int j = 0; j < 8; j++) c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
`else
      c = c ^ b[k];
`endif
    end
    b[8] = c;
    for (int k = 0; k < 9; k++) exp_q.push_back(b[k]);
  endtask

  task automatic wait_frames(input logic [7:0] target, input int budget, input string tag);
    int n;
    n = 0;
    while (fcnt !== target && n < budget) begin
      step(1);
      n++;
    end
    check(tag, {24'd0, fcnt}, {24'd0, target});
  endtask

  // stimulus
  initial begin
    logic [7:0] t2 [9];
    logic [7:0] cur;
    int n;

    step(3);
    do_reset();
    enable = 1'b1;
    busy_len = 1;

    // Reset while a byte is being offered.
    uart_stall = 1'b1;
    sp = 16'h1111; sens = 16'h2222; pid = 16'h3333;
    tick(PT, 0);
    n = 0;
    while (!send && n < 20) begin step(1); n++; end
    check("t1_send_up", {31'd0, send}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("t1_send_async_drop", {31'd0, send}, 32'd0);
    check("t1_data_zero", {24'd0, data}, 32'd0);
    check("t1_fcnt_zero", {24'd0, fcnt}, 32'd0);
    step(1);
    rst_n = 1'b1;
    uart_stall = 1'b0;
    step(1);

    // First frame only after a full period; known-content frame.
    sp = 16'h1234; sens = 16'h0F0F; pid = 16'h00FF;
    tick(PT - 1, 2);
    step(10);
    check("t1_no_early_frame", {24'd0, fcnt}, 32'd0);
`ifdef TELEM_CRC8_EN
    push_frame(8'd0, sp, sens, pid);
`else
    t2 = '{8'hA5, 8'h00, 8'h12, 8'h34, 8'h0F, 8'h0F, 8'h00, 8'hFF, 8'hD9};
    for (int k = 0; k < 9; k++) exp_q.push_back(t2[k]);
`endif
    tick(1, 0);
    wait_frames(8'd1, 300, "t2_frame_cnt");
    check("t2_sb_empty", exp_q.size(), 32'd0);

    // Slower UART, different data, SEQ=1.
    busy_len = 3;
    sp = 16'hBEEF; sens = 16'h8001; pid = 16'h7FFE;
    push_frame(8'd1, sp, sens, pid);
    tick(PT, 1);
    wait_frames(8'd2, 400, "t3_frame_cnt");
    check("t3_sb_empty", exp_q.size(), 32'd0);
    check("t3_no_overrun", {31'd0, ovr}, 32'd0);

    // Overrun while in flight; frame still intact.
    busy_len = 5;
    sp = 16'hC0DE; sens = 16'h5A5A; pid = 16'hFFFF;
    push_frame(8'd2, sp, sens, pid);
    tick(PT, 0);
    tick(PT, 0);
    check("t4_overrun_set", {31'd0, ovr}, 32'd1);
    wait_frames(8'd3, 500, "t4_frame_cnt");
    check("t4_sb_empty", exp_q.size(), 32'd0);
    check("t4_sticky", {31'd0, ovr}, 32'd1);
    clr = 1'b1; step(1); clr = 1'b0;
    check("t4_cleared", {31'd0, ovr}, 32'd0);
    sp = 16'h0001; sens = 16'h0002; pid = 16'h0003;
    push_frame(8'd3, sp, sens, pid);
    tick(PT, 0);
    tick(PT - 1, 0);
    clk_en = 1'b1; clr = 1'b1;
    step(1);
    clk_en = 1'b0; clr = 1'b0;
    check("t4_set_wins", {31'd0, ovr}, 32'd1);
    wait_frames(8'd4, 500, "t4b_frame_cnt");
    check("t4b_sb_empty", exp_q.size(), 32'd0);
    clr = 1'b1; step(1); clr = 1'b0;
    check("t4b_cleared", {31'd0, ovr}, 32'd0);

    // Enable low at the period boundary: nothing happens.
    busy_len = 2;
    enable = 1'b0;
    tick(PT, 0);
    step(20);
    check("t5_no_frame", {24'd0, fcnt}, 32'd4);
    check("t5_no_overrun", {31'd0, ovr}, 32'd0);
    // Enable dropped mid-frame: frame completes, then idle.
    enable = 1'b1;
    sp = 16'hA5A5; sens = 16'h1357; pid = 16'h2468;
    push_frame(8'd4, sp, sens, pid);
    tick(PT, 0);
    n = 0;
    while (exp_q.size() > 6 && n < 100) begin step(1); n++; end
    check("t5_mid_frame", {31'd0, exp_q.size() <= 6}, 32'd1);
    enable = 1'b0;
    wait_frames(8'd5, 400, "t5_frame_cnt");
    check("t5_sb_empty", exp_q.size(), 32'd0);
    tick(PT, 0);
    step(30);
    check("t5_stays_idle", {24'd0, fcnt}, 32'd5);
    check("t5_send_low", {31'd0, send}, 32'd0);

    // Random data through the frame counter wrap.
    enable = 1'b1;
    busy_len = 0;
    cur = 8'd5;
    for (int f = 0; f < 251; f++) begin
      sp   = 16'($urandom_range(0, 65535));
      sens = 16'($urandom_range(0, 65535));
      pid  = 16'($urandom_range(0, 65535));
      push_frame(cur, sp, sens, pid);
      tick(PT, 0);
      cur = cur + 8'd1;
      wait_frames(cur, 200, (cur == 8'd0) ? "t6_wrap" : "t6_frame_cnt");
    end
    check("t6_fcnt_zero", {24'd0, fcnt}, 32'd0);
    check("t6_sb_empty", exp_q.size(), 32'd0);
    check("final_no_overrun", {31'd0, ovr}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound.
  initial begin
    #3000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
